// File: rtl/bulb_bank_controller.sv
// bulb_bank_controller
//   A master switch plus a binary select drives a bank of NUM_BULBS one-hot lamp outputs.
//   The raw master switch is debounced. A registered OFF / STATIC / CHASE state machine
//   chooses the lit bulb. A select code that names no bulb is flagged on sel_err.
//
//   Optional feature macro: BULB_PWM_DIM_EN
//     defined   -> adds the dim_level port and a free-running PWM counter. The lit bulb is
//                  on while pwm_cnt < dim_level.
//     undefined -> no dim_level port and no PWM counter. The selected bulb is fully on.
//
//   There is no valid/ready handshake on this block. sel_in and mode_in are sampled on
//   every rising edge. The outputs are registered, apart from the optional PWM gating.
module bulb_bank_controller #(
    parameter int NUM_BULBS    = 4,
    parameter int SEL_W        = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CHASE_DIV    = 8,
    parameter int PWM_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 master_in,
    input  logic [SEL_W-1:0]     sel_in,
    input  logic                 mode_in,
`ifdef BULB_PWM_DIM_EN
    input  logic [PWM_W-1:0]     dim_level,
`endif
    output logic [NUM_BULBS-1:0] bulbs,
    output logic [SEL_W-1:0]     active_idx,
    output logic                 sel_err,
    output logic [1:0]           state
);

    // State encoding. This is also the external debug encoding on the state port.
    localparam logic [1:0] ST_OFF    = 2'b00;
    localparam logic [1:0] ST_STATIC = 2'b01;
    localparam logic [1:0] ST_CHASE  = 2'b10;

    // Counter widths are sized so that a count of 1 still gets a 1-bit counter.
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int CH_W = $clog2(CHASE_DIV + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHASE_DIV - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_BULBS - 1);

    // The count is one bit wider than sel_in. The range compare then stays meaningful
    // even when NUM_BULBS == 2**SEL_W.
    localparam logic [SEL_W:0]   BULB_CNT  = (SEL_W + 1)'(NUM_BULBS);

    // The PWM width only matters when dimming is built in. An out-of-range width is
    // made visible as a named, empty scope in the elaborated hierarchy.
    if (PWM_W < 1) begin : g_pwm_w_out_of_range
    end

    // Debouncer state.
    logic            master_db;
    logic [DB_W-1:0] db_cnt;

    // FSM and datapath registers, each with its next-value signal.
    logic [1:0]           state_d;
    logic [SEL_W-1:0]     idx_d;
    logic [NUM_BULBS-1:0] lamp_q;
    logic [NUM_BULBS-1:0] lamp_d;
    logic                 err_d;
    logic [CH_W-1:0]      chase_cnt;
    logic [CH_W-1:0]      chase_d;

    // Select decode helpers.
    logic                 sel_valid;
    logic [SEL_W-1:0]     chase_start;
    logic [SEL_W-1:0]     idx_step;

    // One-hot decode of a bulb index.
    function automatic logic [NUM_BULBS-1:0] one_hot(input logic [SEL_W-1:0] i);
        return {{(NUM_BULBS-1){1'b0}}, 1'b1} << i;
    endfunction

    // A select is usable only if it names an existing bulb.
    assign sel_valid   = {1'b0, sel_in} < BULB_CNT;

    // CHASE starts at the selected bulb, or at bulb 0 when the select is out of range.
    assign chase_start = sel_valid ? sel_in : '0;

    // Next bulb in the chase, wrapping from the last bulb back to bulb 0.
    assign idx_step    = (active_idx == LAST_IDX) ? '0 : active_idx + 1'b1;

    // Debounce: master_db flips only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            master_db <= 1'b0;
            db_cnt    <= '0;
        end else if (master_in != master_db) begin
            if (db_cnt == DB_LAST) begin
                master_db <= ~master_db;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Next-state logic. A falling master_db wins over any mode change.
    always_comb begin
        state_d = state;
        case (state)
            ST_OFF: begin
                if (master_db) begin
                    state_d = mode_in ? ST_CHASE : ST_STATIC;
                end
            end
            ST_STATIC: begin
                if (!master_db) begin
                    state_d = ST_OFF;
                end else if (mode_in) begin
                    state_d = ST_CHASE;
                end
            end
            ST_CHASE: begin
                if (!master_db) begin
                    state_d = ST_OFF;
                end else if (!mode_in) begin
                    state_d = ST_STATIC;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Datapath next values. They follow the state being entered, so the bulbs change
    // on the same edge as the state does.
    always_comb begin
        idx_d   = active_idx;
        lamp_d  = lamp_q;
        err_d   = sel_err;
        chase_d = chase_cnt;
        case (state_d)
            ST_OFF: begin
                // The index is held so that it stays observable while the bank is dark.
                lamp_d  = '0;
                err_d   = 1'b0;
                chase_d = '0;
            end
            ST_STATIC: begin
                chase_d = '0;
                if (sel_valid) begin
                    idx_d  = sel_in;
                    lamp_d = one_hot(sel_in);
                    err_d  = 1'b0;
                end else begin
                    // An invalid select darkens the bank. active_idx keeps the last valid value.
                    lamp_d = '0;
                    err_d  = 1'b1;
                end
            end
            ST_CHASE: begin
                err_d = 1'b0;
                if (state != ST_CHASE) begin
                    idx_d   = chase_start;
                    lamp_d  = one_hot(chase_start);
                    chase_d = '0;
                end else if (chase_cnt == CH_LAST) begin
                    idx_d   = idx_step;
                    lamp_d  = one_hot(idx_step);
                    chase_d = '0;
                end else begin
                    lamp_d  = one_hot(active_idx);
                    chase_d = chase_cnt + 1'b1;
                end
            end
            default: begin
                lamp_d  = '0;
                err_d   = 1'b0;
                chase_d = '0;
            end
        endcase
    end

    // FSM and datapath registers. The synchronous reset overrides any state, including CHASE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_OFF;
            active_idx <= '0;
            lamp_q     <= '0;
            sel_err    <= 1'b0;
            chase_cnt  <= '0;
        end else begin
            state      <= state_d;
            active_idx <= idx_d;
            lamp_q     <= lamp_d;
            sel_err    <= err_d;
            chase_cnt  <= chase_d;
        end
    end

`ifdef BULB_PWM_DIM_EN
    logic [PWM_W-1:0] pwm_cnt;

    // Free-running PWM counter. It wraps naturally at 2**PWM_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // The lit bulb is on for dim_level out of every 2**PWM_W cycles. dim_level == 0 keeps it dark.
    assign bulbs = lamp_q & {NUM_BULBS{pwm_cnt < dim_level}};
`else
    assign bulbs = lamp_q;
`endif

endmodule

// File: tb/tb_bulb_bank_controller.sv
// tb_bulb_bank_controller
//   Drives two instances in parallel: the default 4-bulb bank, and a 3-bulb bank that has
//   an unused select code. A behavioural model tracks both banks. It is checked on every
//   negative clock edge, and a directed prologue pins the model with literal values.
module tb_bulb_bank_controller;
    localparam int SEL_W = 2;
    localparam int DEB   = 4;
    localparam int DIV   = 8;
    localparam int PWM_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             master_in;
    logic [SEL_W-1:0] sel_in;
    logic             mode_in;
`ifdef BULB_PWM_DIM_EN
    logic [PWM_W-1:0] dim_level;
`endif

    logic [3:0] bulbs4;
    logic [2:0] bulbs3;
    logic [1:0] idx4, idx3, st4, st3;
    logic       err4, err3;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    bulb_bank_controller #(.NUM_BULBS(4), .SEL_W(SEL_W), .DEBOUNCE_CYC(DEB),
                           .CHASE_DIV(DIV), .PWM_W(PWM_W)) dut4 (
        .clk(clk), .rst(rst), .master_in(master_in), .sel_in(sel_in), .mode_in(mode_in),
`ifdef BULB_PWM_DIM_EN
        .dim_level(dim_level),
`endif
        .bulbs(bulbs4), .active_idx(idx4), .sel_err(err4), .state(st4));

    bulb_bank_controller #(.NUM_BULBS(3), .SEL_W(SEL_W), .DEBOUNCE_CYC(DEB),
                           .CHASE_DIV(DIV), .PWM_W(PWM_W)) dut3 (
        .clk(clk), .rst(rst), .master_in(master_in), .sel_in(sel_in), .mode_in(mode_in),
`ifdef BULB_PWM_DIM_EN
        .dim_level(dim_level),
`endif
        .bulbs(bulbs3), .active_idx(idx3), .sel_err(err3), .state(st3));

    // ---------------- behavioural model ----------------
    // Index 0 models the 4-bulb bank and index 1 the 3-bulb bank.
    // m_mode: 0 dark, 1 static, 2 chase.
    // m_phase: number of cycles the current chase bulb has been lit.
    int nb[2] = '{4, 3};
    bit m_db[2];
    int m_run[2];
    int m_mode[2];
    int m_idx[2];
    int m_phase[2];
    bit m_err[2];
    bit m_lit[2];
    int m_pwm;

    task automatic model_edge(input int k);
        int sel;
        sel = int'(sel_in);
        if (rst) begin
            m_db[k] = 0; m_run[k] = 0; m_mode[k] = 0; m_idx[k] = 0;
            m_phase[k] = 0; m_err[k] = 0; m_lit[k] = 0;
            return;
        end
        // The lamp behaviour follows the debounced switch as it was before this edge.
        if (!m_db[k]) begin
            m_mode[k] = 0; m_lit[k] = 0; m_phase[k] = 0; m_err[k] = 0;
        end else if (!mode_in) begin
            m_mode[k] = 1; m_phase[k] = 0;
            if (sel < nb[k]) begin
                m_idx[k] = sel; m_lit[k] = 1; m_err[k] = 0;
            end else begin
                m_lit[k] = 0; m_err[k] = 1;
            end
        end else if (m_mode[k] != 2) begin
            m_mode[k] = 2; m_idx[k] = (sel < nb[k]) ? sel : 0;
            m_phase[k] = 0; m_lit[k] = 1; m_err[k] = 0;
        end else begin
            m_phase[k] = m_phase[k] + 1;
            if (m_phase[k] == DIV) begin
                m_phase[k] = 0;
                m_idx[k] = (m_idx[k] + 1) % nb[k];
            end
            m_lit[k] = 1; m_err[k] = 0;
        end
        // Debounce: DEB consecutive differing samples flip the switch.
        if (master_in != m_db[k]) begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == DEB) begin
                m_db[k] = !m_db[k];
                m_run[k] = 0;
            end
        end else begin
            m_run[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_edge(k);
        if (rst) m_pwm = 0;
        else     m_pwm = (m_pwm + 1) % (1 << PWM_W);
    end

    // Brightness mask that the model predicts for this cycle.
    function automatic logic [31:0] gate();
`ifdef BULB_PWM_DIM_EN
        return (m_pwm < int'(dim_level)) ? 32'hFFFF_FFFF : 32'h0;
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    function automatic logic [31:0] exp_bulbs(input int k);
        logic [31:0] v;
        v = m_lit[k] ? (32'd1 << m_idx[k]) : 32'd0;
        return v & gate();
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Checks every output of both banks against the model on every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("bulbs4", 32'(bulbs4), exp_bulbs(0));
            check("idx4",   32'(idx4),   32'(m_idx[0]));
            check("err4",   32'(err4),   32'(m_err[0]));
            check("state4", 32'(st4),    32'(m_mode[0]));
            check("bulbs3", 32'(bulbs3), exp_bulbs(1));
            check("idx3",   32'(idx3),   32'(m_idx[1]));
            check("err3",   32'(err3),   32'(m_err[1]));
            check("state3", 32'(st3),    32'(m_mode[1]));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    bit master_tgt;

    initial begin
        rst       = 1'b1;
        master_in = 1'($urandom_range(0, 1));
        sel_in    = SEL_W'($urandom_range(0, 3));
        mode_in   = 1'($urandom_range(0, 1));
`ifdef BULB_PWM_DIM_EN
        dim_level = PWM_W'($urandom_range(1, 15));
`endif
        cyc();
        cmp_en = 1'b1;
        cyc();
        // Reset state, whatever the inputs are.
        check("rst_bulbs4", 32'(bulbs4), 32'h0);
        check("rst_idx4",   32'(idx4),   32'h0);
        check("rst_err4",   32'(err4),   32'h0);
        check("rst_state4", 32'(st4),    32'h0);

        rst = 1'b0; master_in = 1'b0; sel_in = 2'd0; mode_in = 1'b0;
        cycles(2);
        // A 3-sample glitch must not get through the debouncer.
        master_in = 1'b1;
        cycles(3);
        master_in = 1'b0;
        cycles(3);
        check("glitch_state4", 32'(st4), 32'h0);
        check("glitch_bulbs4", 32'(bulbs4), 32'h0);
        // Held high: the bulbs change on the 5th edge.
        master_in = 1'b1; sel_in = 2'd2; mode_in = 1'b0;
        cycles(4);
        check("hold_e4_bulbs4", 32'(bulbs4), 32'h0);
        cyc();
        check("hold_e5_bulbs4", 32'(bulbs4), 32'b0100 & gate());
        check("hold_e5_bulbs3", 32'(bulbs3), 32'b100 & gate());

        // An out-of-range select on the 3-bulb bank.
        sel_in = 2'd3;
        cyc();
        check("inv_bulbs3", 32'(bulbs3), 32'h0);
        check("inv_err3",   32'(err3),   32'h1);
        check("inv_idx3",   32'(idx3),   32'h2);
        check("inv_bulbs4", 32'(bulbs4), 32'b1000 & gate());
        sel_in = 2'd0;
        cyc();
        check("rec_bulbs3", 32'(bulbs3), 32'b001 & gate());
        check("rec_err3",   32'(err3),   32'h0);

        // CHASE from bulb 3: lit for 8 cycles, then wraps to bulb 0, then moves to bulb 1.
        sel_in = 2'd3; mode_in = 1'b1;
        cyc();
        check("ch_entry_bulbs4", 32'(bulbs4), 32'b1000 & gate());
        check("ch_entry_state4", 32'(st4),    32'b10);
        check("ch_entry_bulbs3", 32'(bulbs3), 32'b001 & gate());
        cycles(7);
        check("ch_e7_bulbs4", 32'(bulbs4), 32'b1000 & gate());
        cyc();
        check("ch_wrap_bulbs4", 32'(bulbs4), 32'b0001 & gate());
        check("ch_wrap_bulbs3", 32'(bulbs3), 32'b010 & gate());
        cycles(7);
        check("ch_e15_bulbs4", 32'(bulbs4), 32'b0001 & gate());
        cyc();
        check("ch_e16_bulbs4", 32'(bulbs4), 32'b0010 & gate());

        // The master switch drops in the middle of a chase.
        master_in = 1'b0;
        cycles(4);
        check("off_e4_state4", 32'(st4), 32'b10);
        cyc();
        check("off_e5_bulbs4", 32'(bulbs4), 32'h0);
        check("off_e5_state4", 32'(st4),    32'h0);
        check("off_e5_idx4",   32'(idx4),   32'h1);

        // Reset in the middle of a chase.
        master_in = 1'b1;
        cycles(8);
        check("pre_rst_state4", 32'(st4), 32'b10);
        rst = 1'b1;
        cyc();
        check("mid_rst_bulbs4", 32'(bulbs4), 32'h0);
        check("mid_rst_idx4",   32'(idx4),   32'h0);
        check("mid_rst_state4", 32'(st4),    32'h0);
        rst = 1'b0;

        // Randomized operation with glitches, select/mode changes and occasional resets.
        master_tgt = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 59) == 0) master_tgt = ~master_tgt;
            master_in = master_tgt ^ ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0)   sel_in  = SEL_W'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0)  mode_in = ~mode_in;
            rst = ($urandom_range(0, 499) == 0);
`ifdef BULB_PWM_DIM_EN
            if ($urandom_range(0, 29) == 0)  dim_level = PWM_W'($urandom_range(0, 15));
`endif
            cyc();
        end
        rst = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
